// File: rtl/sram_mp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_mp_arbiter
// Purpose  : Round-robin multi-channel front end for a single-port SRAM macro
//            with byte-enable writes and a latency-matched read return path.
// Revision : 1.0
// ============================================================================
module sram_mp_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 256,
    parameter int NUM_CH = 2,
    parameter int RD_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            req_wen,
    input  logic [NUM_CH*ADDR_W-1:0]     req_addr,
    input  logic [NUM_CH*DATA_W-1:0]     req_wdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0] req_be,
    output logic [NUM_CH-1:0]            rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    input  logic                         sram_busy,
    output logic                         sram_cs,
    output logic                         sram_we,
    output logic [ADDR_W-1:0]            sram_addr,
    output logic [DATA_W-1:0]            sram_din,
    output logic [DATA_W/8-1:0]          sram_be,
    input  logic [DATA_W-1:0]            sram_dout
);

    localparam int BE_W = DATA_W / 8;
    localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [ID_W-1:0]   r_ptr;
    logic              w_found;
    logic [ID_W-1:0]   w_sel;
    int                w_pos;
    logic              w_gnt_any;
    logic [NUM_CH-1:0] w_gnt_oh;

    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [BE_W-1:0]   w_be;
    logic              w_wen;

    logic              r_cmd_rd;
    logic [ID_W-1:0]   r_cmd_id;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [ID_W-1:0]   r_pipe_id [RD_LAT];

    // Scan channels starting at the pointer, wrapping, and take the first valid one.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_pos   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= NUM_CH) begin
                w_pos = w_pos - NUM_CH;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (!w_found && (c == w_pos) && req_valid[c]) begin
                    w_found = 1'b1;
                    w_sel   = ID_W'(c);
                end
            end
        end
    end

    assign w_gnt_any = w_found & ~sram_busy & rstn;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_grant
            assign w_gnt_oh[g] = w_gnt_any && (w_sel == ID_W'(g));
        end
    endgenerate

    assign req_ready = w_gnt_oh;

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        w_wen   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_gnt_oh[c]) begin
                w_addr  = req_addr[c*ADDR_W +: ADDR_W];
                w_wdata = req_wdata[c*DATA_W +: DATA_W];
                w_be    = req_be[c*BE_W +: BE_W];
                w_wen   = req_wen[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (w_gnt_any) begin
            r_ptr <= (w_sel == ID_W'(NUM_CH - 1)) ? '0 : w_sel + 1'b1;
        end
    end

    // Address, data and byte enables only move on a grant so idle cycles hold them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sram_cs   <= 1'b0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            sram_be   <= '0;
        end else begin
            sram_cs <= w_gnt_any;
            sram_we <= w_gnt_any & w_wen;
            if (w_gnt_any) begin
                sram_addr <= w_addr;
                sram_din  <= w_wdata;
                sram_be   <= w_wen ? w_be : {BE_W{1'b1}};
            end
        end
    end

    // The command-cycle tag plus RD_LAT shift stages line up with sram_dout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cmd_rd   <= 1'b0;
            r_cmd_id   <= '0;
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_id[i] <= '0;
            end
        end else begin
            r_cmd_rd      <= w_gnt_any & ~w_wen;
            r_cmd_id      <= w_sel;
            r_pipe_vld[0] <= r_cmd_rd;
            r_pipe_id[0]  <= r_cmd_id;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                rsp_valid[c] <= r_pipe_vld[RD_LAT-1] && (r_pipe_id[RD_LAT-1] == ID_W'(c));
            end
            if (r_pipe_vld[RD_LAT-1]) begin
                rsp_rdata <= sram_dout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_mp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_mp_arbiter
// Purpose  : Directed bench for sram_mp_arbiter (4-ch/RD_LAT=1 and 2-ch/RD_LAT=4).
// Revision : 1.0
// ============================================================================
module tb_sram_mp_arbiter;

    localparam int AW = 15;
    localparam int DW = 256;
    localparam int BW = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Instance A: four channels, single-cycle macro
    logic [3:0]      a_valid, a_ready, a_wen, a_rsp_valid;
    logic [4*AW-1:0] a_addr;
    logic [4*DW-1:0] a_wdata;
    logic [4*BW-1:0] a_be;
    logic [DW-1:0]   a_rdata, a_din, a_dout;
    logic            a_busy, a_cs, a_we;
    logic [AW-1:0]   a_saddr;
    logic [BW-1:0]   a_sbe;

    // Instance B: two channels, four-cycle macro
    logic [1:0]      b_valid, b_ready, b_wen, b_rsp_valid;
    logic [2*AW-1:0] b_addr;
    logic [2*DW-1:0] b_wdata;
    logic [2*BW-1:0] b_be;
    logic [DW-1:0]   b_rdata, b_din, b_dout;
    logic            b_busy, b_cs, b_we;
    logic [AW-1:0]   b_saddr;
    logic [BW-1:0]   b_sbe;

    sram_mp_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(4), .RD_LAT(1)) dut_a (
        .clk(clk), .rstn(rstn),
        .req_valid(a_valid), .req_ready(a_ready), .req_wen(a_wen),
        .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata),
        .sram_busy(a_busy), .sram_cs(a_cs), .sram_we(a_we), .sram_addr(a_saddr),
        .sram_din(a_din), .sram_be(a_sbe), .sram_dout(a_dout)
    );

    sram_mp_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(2), .RD_LAT(4)) dut_b (
        .clk(clk), .rstn(rstn),
        .req_valid(b_valid), .req_ready(b_ready), .req_wen(b_wen),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
        .sram_busy(b_busy), .sram_cs(b_cs), .sram_we(b_we), .sram_addr(b_saddr),
        .sram_din(b_din), .sram_be(b_sbe), .sram_dout(b_dout)
    );

    // Macro model A: byte-masked writes, read data one cycle after the command
    logic [DW-1:0] mem_a [0:32767];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < BW; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (a_cs) begin
            if (a_we) mem_a[a_saddr] <= merge(mem_a[a_saddr], a_din, a_sbe);
            else      a_dout <= mem_a[a_saddr];
        end
    end

    // Macro model B: address-derived read data, four cycles after the command
    function automatic logic [DW-1:0] pat_b(input logic [AW-1:0] a);
        return {16{1'b0, a}};
    endfunction

    function automatic logic [DW-1:0] pat_a(input int c);
        return {32{8'(16 + c)}};
    endfunction

    function automatic int ch_of(input logic [3:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = i;
        return r;
    endfunction

    logic [DW-1:0] b_dp [4];
    always @(posedge clk) begin
        b_dp[0] <= (b_cs && !b_we) ? pat_b(b_saddr) : '0;
        for (int i = 1; i < 4; i++) b_dp[i] <= b_dp[i-1];
    end
    assign b_dout = b_dp[3];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       busy;
        logic [3:0] exp_ready;
    } vec_t;

    vec_t vec [25];

    logic [1:0]    b_seq_valid [10] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0]    b_seq_rsp   [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
    logic [AW-1:0] b_seq_addr  [10] = '{15'h20, 15'h21, 15'h22, 0, 0, 0, 15'h20, 15'h21, 15'h22, 0};

    initial begin
        logic          exp_cs;
        logic [3:0]    exp_rsp;

        // contention, hand-computed round-robin order starting at ptr 0
        vec[0]  = '{4'b1111, 1'b0, 4'b0001};
        vec[1]  = '{4'b1111, 1'b0, 4'b0010};
        vec[2]  = '{4'b1111, 1'b0, 4'b0100};
        vec[3]  = '{4'b1111, 1'b0, 4'b1000};
        vec[4]  = '{4'b1111, 1'b0, 4'b0001};
        vec[5]  = '{4'b1111, 1'b0, 4'b0010};
        vec[6]  = '{4'b1111, 1'b0, 4'b0100};
        vec[7]  = '{4'b1111, 1'b0, 4'b1000};
        vec[8]  = '{4'b0000, 1'b0, 4'b0000};
        vec[9]  = '{4'b1010, 1'b0, 4'b0010};
        vec[10] = '{4'b1010, 1'b0, 4'b1000};
        vec[11] = '{4'b0101, 1'b1, 4'b0000};
        vec[12] = '{4'b0101, 1'b0, 4'b0001};
        vec[13] = '{4'b0101, 1'b0, 4'b0100};
        vec[14] = '{4'b0001, 1'b0, 4'b0001};
        vec[15] = '{4'b1000, 1'b0, 4'b1000};
        vec[16] = '{4'b0110, 1'b0, 4'b0010};
        // two reads in flight, then three busy cycles
        vec[17] = '{4'b0100, 1'b0, 4'b0100};
        vec[18] = '{4'b1000, 1'b0, 4'b1000};
        vec[19] = '{4'b0011, 1'b1, 4'b0000};
        vec[20] = '{4'b0011, 1'b1, 4'b0000};
        vec[21] = '{4'b0011, 1'b1, 4'b0000};
        vec[22] = '{4'b0011, 1'b0, 4'b0001};
        vec[23] = '{4'b0010, 1'b0, 4'b0010};
        vec[24] = '{4'b0000, 1'b0, 4'b0000};

        for (int i = 0; i < 32768; i++) mem_a[i] = '0;
        mem_a[16] = {32{8'hA5}};
        for (int c = 0; c < 4; c++) mem_a[256 + c] = pat_a(c);

        a_valid = '0; a_wen = '0; a_wdata = '0; a_be = '0; a_busy = 1'b0;
        b_valid = '0; b_wen = '0; b_wdata = '0; b_be = '0; b_busy = 1'b0;
        for (int c = 0; c < 4; c++) a_addr[c*AW +: AW] = AW'(256 + c);
        b_addr = {15'h21, 15'h20};

        // reset state
        #2;
        chk("rst_a_cs", a_cs, 0);
        chk("rst_a_we", a_we, 0);
        chk("rst_a_addr", a_saddr, 0);
        chk("rst_a_din", a_din, 0);
        chk("rst_a_be", a_sbe, 0);
        chk("rst_a_rsp_valid", a_rsp_valid, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_cs", b_cs, 0);
        chk("rst_b_rsp_valid", b_rsp_valid, 0);
        cyc(); cyc();
        rstn = 1'b1;

        // table: grant order, command issue, response return
        for (int s = 0; s < 25; s++) begin
            a_valid = vec[s].valid;
            a_busy  = vec[s].busy;
            @(negedge clk);
            chk("tbl_ready", a_ready, vec[s].exp_ready);
            exp_cs = (s > 0) ? (vec[s > 0 ? s-1 : 0].exp_ready != 0) : 1'b0;
            chk("tbl_cs", a_cs, exp_cs);
            if (exp_cs) chk("tbl_addr", a_saddr, AW'(256 + ch_of(vec[s-1].exp_ready)));
            exp_rsp = (s >= 3) ? vec[s >= 3 ? s-3 : 0].exp_ready : 4'b0000;
            chk("tbl_rsp_valid", a_rsp_valid, exp_rsp);
            if (exp_rsp != 0) chk("tbl_rsp_rdata", a_rdata, pat_a(ch_of(exp_rsp)));
            cyc();
        end
        a_valid = '0; a_busy = 1'b0;
        repeat (4) cyc();

        // single read on ch0
        a_addr[0 +: AW] = 15'h0010;
        a_valid = 4'b0001;
        @(negedge clk); chk("rd_ready", a_ready, 4'b0001);
        cyc(); a_valid = '0;
        @(negedge clk);
        chk("rd_cs", a_cs, 1);
        chk("rd_we", a_we, 0);
        chk("rd_addr", a_saddr, 15'h0010);
        chk("rd_be", a_sbe, 32'hFFFF_FFFF);
        chk("rd_rsp_early0", a_rsp_valid, 0);
        cyc(); @(negedge clk);
        chk("rd_rsp_early1", a_rsp_valid, 0);
        cyc(); @(negedge clk);
        chk("rd_rsp_valid", a_rsp_valid, 4'b0001);
        chk("rd_rsp_rdata", a_rdata, {32{8'hA5}});
        cyc(); @(negedge clk);
        chk("rd_rsp_once", a_rsp_valid, 0);
        chk("rd_rdata_hold", a_rdata, {32{8'hA5}});
        repeat (2) cyc();

        // write byte 0 on ch1, then read it back
        a_addr[AW +: AW]  = 15'h7FFF;
        a_wdata[DW +: DW] = {DW{1'b1}};
        a_be[BW +: BW]    = 32'h0000_0001;
        a_wen   = 4'b0010;
        a_valid = 4'b0010;
        @(negedge clk); chk("wr_ready", a_ready, 4'b0010);
        cyc(); a_wen = 4'b0000;
        @(negedge clk);
        chk("wr_rd_ready", a_ready, 4'b0010);
        chk("wr_cs", a_cs, 1);
        chk("wr_we", a_we, 1);
        chk("wr_addr", a_saddr, 15'h7FFF);
        chk("wr_be", a_sbe, 32'h0000_0001);
        chk("wr_din", a_din, {DW{1'b1}});
        cyc(); a_valid = '0;
        @(negedge clk);
        chk("wr_rd_we", a_we, 0);
        chk("wr_rd_be", a_sbe, 32'hFFFF_FFFF);
        cyc(); @(negedge clk);
        chk("wr_no_rsp", a_rsp_valid, 0);
        cyc(); @(negedge clk);
        chk("wr_rd_rsp_valid", a_rsp_valid, 4'b0010);
        chk("wr_rd_rsp_rdata", a_rdata, {{(DW-8){1'b0}}, 8'hFF});
        repeat (2) cyc();

        // RD_LAT=4 back-to-back reads ch0, ch1, ch0
        for (int s = 0; s < 10; s++) begin
            if (s == 2) b_addr[0 +: AW] = 15'h22;
            b_valid = b_seq_valid[s];
            @(negedge clk);
            if (s < 3) chk("lat4_ready", b_ready, b_seq_valid[s]);
            chk("lat4_rsp_valid", b_rsp_valid, b_seq_rsp[s]);
            if (b_seq_rsp[s] != 0) chk("lat4_rsp_rdata", b_rdata, pat_b(b_seq_addr[s]));
            cyc();
        end

        // reset with two reads in flight
        a_valid = 4'b0100;
        @(negedge clk); chk("rfl_ready0", a_ready, 4'b0100);
        cyc(); a_valid = 4'b0001;
        @(negedge clk); chk("rfl_ready1", a_ready, 4'b0001);
        cyc(); a_valid = 4'b0010;
        rstn = 1'b0;
        #1;
        chk("rfl_cs", a_cs, 0);
        chk("rfl_we", a_we, 0);
        chk("rfl_addr", a_saddr, 0);
        chk("rfl_din", a_din, 0);
        chk("rfl_be", a_sbe, 0);
        chk("rfl_rsp_valid", a_rsp_valid, 0);
        chk("rfl_rdata", a_rdata, 0);
        chk("rfl_ready_in_rst", a_ready, 0);
        cyc(); cyc();
        a_valid = '0;
        rstn = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("rfl_no_rsp", a_rsp_valid, 0);
            cyc();
        end
        a_valid = 4'b1111;
        @(negedge clk); chk("rfl_first_grant", a_ready, 4'b0001);
        cyc(); a_valid = '0;
        repeat (4) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_mp_arbiter.md
Name: sram_mp_arbiter

Overview:
- Parametrised multi-channel front end for a single-port synchronous SRAM macro.
- Replaces the single-requester addr/din/wen drive model with:
  - NUM_CH valid/ready request channels
  - round-robin arbitration
  - byte-enable writes
  - a configurable read-latency return pipeline that routes read data back to the issuing channel
  - backpressure from the macro (sram_busy).

Parameters:
ADDR_W  15  SRAM word-address width
DATA_W  256  SRAM data width; must be a multiple of 8
NUM_CH  2  number of requester channels, 1..8
RD_LAT  1  macro read latency in cycles, from command cycle to dout valid, 1..4
BE_W  DATA_W/8  derived byte-enable width; not overridable

Ports:
clk  in  1  clock
rstn  in  1  reset
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel grant/accept
req_wen  in  NUM_CH  1=write, 0=read
req_addr  in  NUM_CH*ADDR_W  channel i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
req_be  in  NUM_CH*BE_W  byte enables, writes only
rsp_valid  out  NUM_CH  one-hot read-data valid, per channel
rsp_rdata  out  DATA_W  read data, shared by all channels
sram_busy  in  1  macro cannot accept a command this cycle
sram_cs  out  1  macro chip select
sram_we  out  1  macro write enable
sram_addr  out  ADDR_W  macro address
sram_din  out  DATA_W  macro write data
sram_be  out  BE_W  macro byte enables
sram_dout  in  DATA_W  macro read data

Behaviour:
- Reset: rstn asynchronous, active-low; clock clk.
  - All outputs 0.
  - RR pointer = 0.
  - Read pipeline cleared.
- Handshake: transfer on channel i at a clk edge when req_valid[i] & req_ready[i].
  - Requester holds valid and payload stable until accepted.
  - valid must not depend on ready.
- Arbitration (combinational):
  - If sram_busy=1: req_ready = 0.
  - Else req_ready is one-hot at the first channel with valid set, searching from ptr upward with wrap.
  - Zero if no valid.
- RR pointer: on each grant to channel g, ptr <= (g+1) mod NUM_CH. Unchanged when nothing is granted.
- Command issue (registered): in the cycle after grant, sram_cs=1 and the granted payload appears on the macro pins.
  - sram_we = req_wen.
  - sram_be = req_be for writes, all-ones for reads.
- Idle cycle (no grant): sram_cs=0, sram_we=0. sram_addr/din/be hold their last values.
- Throughput: one command per cycle, back-to-back, no bubbles.
- Write with be=0: still issued (cs=1, we=1, be=0); memory unchanged.
- Read return: a shift pipeline of depth RD_LAT carries {valid, channel id} alongside each read command.
  - Command cycle C: sram_dout is valid in cycle C+RD_LAT.
  - Block registers it: rsp_rdata updates and rsp_valid[ch] = 1 for exactly one cycle in C+RD_LAT+1.
- Read latency from handshake edge T: rsp_valid asserted in cycle T+RD_LAT+2 (T+3 at RD_LAT=1).
- rsp_rdata holds its value when rsp_valid=0.
- Writes produce no response.
- Ordering: commands are issued in grant order. A read after a write to the same address returns the new data.
- sram_busy asserted mid-stream:
  - Blocks new grants only.
  - In-flight reads continue and return on schedule.
  - No response is dropped or duplicated.
- Reset mid-operation: in-flight reads are discarded; no rsp_valid after rstn deasserts until new reads issue.
- NUM_CH=1: arbiter degenerates to req_ready = req_valid & ~sram_busy.

Test Plan:
- Single read, RD_LAT=1: ch0 reads addr 0x0010 at edge T; macro returns 0xA5..A5 -> sram_cs=1 in T+1, rsp_valid[0]=1 with 0xA5..A5 in T+3 only.
- Write then read, be=0x0000_0001 (byte 0 only): ch1 writes 0xFF..FF to 0x7FFF, then reads it back -> byte 0 = 0xFF, other bytes retain prior 0x00; response on rsp_valid[1] only.
- Contention, NUM_CH=4: all channels valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; sram_cs=1 in every cycle.
- Backpressure: sram_busy=1 for 3 cycles while ch0/ch1 valid and 2 reads in flight -> req_ready=0 for those cycles; both in-flight responses still return on schedule; grants resume the cycle sram_busy drops.
- RD_LAT=4 back-to-back reads from ch0,ch1,ch0 at consecutive edges -> rsp_valid one-hot 0,1,0 in three consecutive cycles, starting 6 cycles after the first handshake edge.
- Reset mid-flight: assert rstn=0 one cycle after 2 reads issue -> all outputs 0 immediately; no rsp_valid after release; next grant goes to ch0.
